ofifo_sync: RTL

Parametrised next-generation output FIFO for the systolic array's result path.
- COL independent column FIFOs of configurable DEPTH take per-column write strobes from the PE array.
- A row-aligned read pops one word from every column at once, with a registered output and an explicit read-valid strobe.
- Adds almost-full back-pressure, occupancy reporting and error detection. Sits between the MAC array and the SFU/output buffer.

---
 rtl/ofifo_pkg.sv | 20 ++
 rtl/ofifo_sync_if.sv | 34 +++
 rtl/ofifo_col.sv | 49 ++++
 rtl/ofifo_sync.sv | 106 ++++++++++
 4 files changed

// File: rtl/ofifo_pkg.sv
// Shared defaults and helpers for the systolic-array output FIFO.
package ofifo_pkg;

  localparam int unsigned OfifoCol   = 8;
  localparam int unsigned OfifoBw    = 16;
  localparam int unsigned OfifoDepth = 64;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Back-pressure leaves four slots of slack for in-flight PE writes.
  function automatic int unsigned af_level(input int unsigned depth);
    return depth - 4;
  endfunction

endpackage

// File: rtl/ofifo_sync_if.sv
// Bus between the PE array / SFU side (master) and ofifo_sync (slave).
interface ofifo_sync_if
  import ofifo_pkg::*;
#(
  parameter int unsigned COL   = OfifoCol,
  parameter int unsigned BW    = OfifoBw,
  parameter int unsigned DEPTH = OfifoDepth,
  parameter int unsigned AW    = clog2(DEPTH)
);
  logic [COL-1:0]    wr;
  logic [BW*COL-1:0] in;
  logic              rd;
  logic [BW*COL-1:0] out;
  logic              o_rd_valid;
  logic              o_valid;
  logic              o_full;
  logic              o_almost_full;
  logic              o_ready;
  logic [AW:0]       o_min_count;
  logic              o_overflow;
  logic              o_underflow;

  modport master (
    output wr, in, rd,
    input  out, o_rd_valid, o_valid, o_full, o_almost_full, o_ready,
    input  o_min_count, o_overflow, o_underflow
  );

  modport slave (
    input  wr, in, rd,
    output out, o_rd_valid, o_valid, o_full, o_almost_full, o_ready,
    output o_min_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/ofifo_col.sv
// Single-column synchronous FIFO; push/pop are pre-qualified by the top level.
module ofifo_col #(
  parameter int unsigned BW    = 16,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [BW-1:0] wdata,
  output logic [BW-1:0] head,
  output logic [AW:0]   count
);

  logic [BW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ofifo_sync.sv
// Row-aligned output FIFO: COL column FIFOs, one registered row pop per rd.
// Status min-count and sticky error flags are built only with OFIFO_STATUS_EN.
module ofifo_sync
  import ofifo_pkg::*;
#(
  parameter int unsigned COL      = OfifoCol,
  parameter int unsigned BW       = OfifoBw,
  parameter int unsigned DEPTH    = OfifoDepth,
  parameter int unsigned AF_LEVEL = af_level(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  ofifo_sync_if.slave  bus
);

  localparam int unsigned AW       = clog2(DEPTH);
  localparam logic [AW:0] FullCnt  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AfullCnt = (AW+1)'(AF_LEVEL);

  logic [COL-1:0][AW:0]   count;
  logic [COL-1:0][BW-1:0] head;
  logic [COL-1:0]         accept, nonempty, at_full, at_afull;
  logic                   valid, pop;
  logic [COL-1:0][BW-1:0] out_q;
  logic                   rd_valid_q;

  always_comb begin
    nonempty = '0;
    at_full  = '0;
    at_afull = '0;
    for (int i = 0; i < COL; i++) begin
      nonempty[i] = (count[i] != '0);
      at_full[i]  = (count[i] == FullCnt);
      at_afull[i] = (count[i] >= AfullCnt);
    end
  end

  assign valid  = &nonempty;
  assign pop    = bus.rd & valid;
  // A full column can still take a word when the row pop frees a slot.
  assign accept = bus.wr & (~at_full | {COL{pop}});

  for (genvar g = 0; g < COL; g++) begin : g_col
    ofifo_col #(
      .BW    (BW),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .push  (accept[g]),
      .pop   (pop),
      .wdata (bus.in[BW*g +: BW]),
      .head  (head[g]),
      .count (count[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      if (pop) out_q <= head;
    end
  end

  assign bus.out           = out_q;
  assign bus.o_rd_valid    = rd_valid_q;
  assign bus.o_valid       = valid;
  assign bus.o_full        = |at_full;
  assign bus.o_almost_full = |at_afull;
  assign bus.o_ready       = ~(|at_full);

`ifdef OFIFO_STATUS_EN
  logic [AW:0] min_count;
  logic        overflow_q, underflow_q;

  always_comb begin
    min_count = count[0];
    for (int i = 1; i < COL; i++) begin
      if (count[i] < min_count) min_count = count[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (|(bus.wr & at_full) && !pop) overflow_q <= 1'b1;
      if (bus.rd && !valid)             underflow_q <= 1'b1;
    end
  end

  assign bus.o_min_count = min_count;
  assign bus.o_overflow  = overflow_q;
  assign bus.o_underflow = underflow_q;
`else
  assign bus.o_min_count = '0;
  assign bus.o_overflow  = 1'b0;
  assign bus.o_underflow = 1'b0;
`endif

endmodule
